// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle execute-stage ALU.
// Operation encodings match the ALU controller's 4-bit output.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int SHAMT_W        = $clog2(ALU_DATA_WIDTH);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_AND  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_SRA  = 4'b0110,
        OP_SRL  = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_ILL9 = 4'b1001,
        OP_BNE  = 4'b1010,
        OP_BLT  = 4'b1011,
        OP_BGE  = 4'b1100,
        OP_BEQ  = 4'b1101,
        OP_LUI  = 4'b1110,
        OP_ILLF = 4'b1111
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_shift_step.sv
// One iteration of the iterative shifter: shifts value by a small amount k.
// k never exceeds SHIFT_STEP, so this stays a narrow mux instead of a barrel.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KW         = 6
) (
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [KW-1:0]         k,
    input  alu_op_t               op,
    output logic [DATA_WIDTH-1:0] shifted
);

    // Select the fill rule by shift flavour.
    always_comb begin
        shifted = value;
        case (op)
            OP_SRA:  shifted = $signed(value) >>> k;
            OP_SRL:  shifted = value >> k;
            OP_SLL:  shifted = value << k;
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle arithmetic/logic/branch ops, iterative shifts.
// Valid/ready input, registered one-cycle out_valid pulse, flush aborts a shift.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  BranchTaken,
    output logic                  Illegal
);

    localparam int SW = $clog2(DATA_WIDTH);
    // One extra bit so a step of 8 still fits when DATA_WIDTH is small.
    localparam int KW = SW + 1;
    localparam logic [KW-1:0] STEP_K = KW'(SHIFT_STEP);

    alu_state_t            state_q, state_d;
    alu_op_t               op_q, op_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic [KW-1:0]         rem_q, rem_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  branch_q, branch_d;
    logic                  illegal_q, illegal_d;

    alu_op_t               op_s;
    logic [DATA_WIDTH-1:0] res_s;
    logic                  br_s;
    logic                  ill_s;
    logic                  is_shift_s;
    logic                  lt_s;
    logic                  eq_s;
    logic                  accept_s;
    logic [KW-1:0]         shamt_s;
    logic [KW-1:0]         k_s;
    logic [DATA_WIDTH-1:0] shifted_s;

    assign op_s     = alu_op_t'(Operation);
    assign lt_s     = $signed(SrcA) < $signed(SrcB);
    assign eq_s     = (SrcA == SrcB);
    assign shamt_s  = {1'b0, SrcB[SW-1:0]};
    assign accept_s = in_valid && (state_q == ST_IDLE) && !flush;
    assign k_s      = (rem_q < STEP_K) ? rem_q : STEP_K;

    alu_shift_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .KW         (KW)
    ) u_shift_step (
        .value   (val_q),
        .k       (k_s),
        .op      (op_q),
        .shifted (shifted_s)
    );

    // Single-cycle datapath; shifts only flag themselves here.
    always_comb begin
        res_s      = {DATA_WIDTH{1'b0}};
        br_s       = 1'b0;
        ill_s      = 1'b0;
        is_shift_s = 1'b0;
        case (op_s)
            OP_ADD:  res_s = SrcA + SrcB;
            OP_SUB:  res_s = SrcA - SrcB;
            OP_XOR:  res_s = SrcA ^ SrcB;
            OP_OR:   res_s = SrcA | SrcB;
            OP_AND:  res_s = SrcA & SrcB;
            OP_SLT:  res_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            OP_SRA, OP_SRL, OP_SLL: begin
                is_shift_s = 1'b1;
                res_s      = SrcA;
            end
            OP_BNE: begin
                br_s  = ~eq_s;
                res_s = {{(DATA_WIDTH-1){1'b0}}, ~eq_s};
            end
            OP_BLT: begin
                br_s  = lt_s;
                res_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            end
            OP_BGE: begin
                br_s  = ~lt_s;
                res_s = {{(DATA_WIDTH-1){1'b0}}, ~lt_s};
            end
            OP_BEQ: begin
                br_s  = eq_s;
                res_s = {{(DATA_WIDTH-1){1'b0}}, eq_s};
            end
            OP_LUI:  res_s = SrcB;
            default: ill_s = 1'b1;
        endcase
    end

    // Next-state and output register computation for the IDLE/SHIFT FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        val_d       = val_q;
        rem_d       = rem_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        branch_d    = branch_q;
        illegal_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && is_shift_s && (shamt_s != {KW{1'b0}})) begin
                    state_d = ST_SHIFT;
                    op_d    = op_s;
                    val_d   = SrcA;
                    rem_d   = shamt_s;
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    result_d    = res_s;
                    branch_d    = br_s;
                    illegal_d   = ill_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    rem_d   = {KW{1'b0}};
                end else if (rem_q == k_s) begin
                    state_d     = ST_IDLE;
                    val_d       = shifted_s;
                    rem_d       = {KW{1'b0}};
                    out_valid_d = 1'b1;
                    result_d    = shifted_s;
                    branch_d    = 1'b0;
                end else begin
                    val_d = shifted_s;
                    rem_d = rem_q - k_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            val_q       <= {DATA_WIDTH{1'b0}};
            rem_q       <= {KW{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {DATA_WIDTH{1'b0}};
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            val_q       <= val_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            branch_q    <= branch_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = out_valid_q;
    assign ALUResult   = result_q;
    assign BranchTaken = branch_q;
    assign Illegal     = illegal_q;

endmodule
